// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared widths, conversion length and FSM states for the frequency generator
package freq_gen_pkg;
    localparam int BCD_W = 4;
    localparam int DIGITS = 6;
    localparam int ACC_W = 32;
    localparam int CONV_CYC = 6;
    typedef enum logic [2:0] {IDLE, CONV, CHECK, DIV, APPLY} state_t;
endpackage

// File: rtl/freq_gen_if.sv
// freq_gen_if: request/status bundle of the generator; FREQ_GEN_PULSE_CNT_EN adds pulse_cnt
interface freq_gen_if;
    import freq_gen_pkg::*;
    logic load;
    logic [DIGITS-1:0][BCD_W-1:0] d;
    logic busy;
    logic err;
    logic f_out;
`ifdef FREQ_GEN_PULSE_CNT_EN
    logic [ACC_W-1:0] pulse_cnt;
    modport master (output load, d, input busy, err, f_out, pulse_cnt);
    modport slave (input load, d, output busy, err, f_out, pulse_cnt);
`else
    modport master (output load, d, input busy, err, f_out);
    modport slave (input load, d, output busy, err, f_out);
`endif
endinterface

// File: rtl/freq_gen_div.sv
// freq_gen_div: serial restoring unsigned divider, one quotient bit per cycle, W cycles per divide
module freq_gen_div
    import freq_gen_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] rem;
    logic [W-1:0] dsr;
    logic [CW-1:0] cnt;
    logic [W:0] trial;
    logic [W:0] diff;
    logic ge;
    // Trial subtraction of the divisor from the shifted partial remainder; done flags the last step
    always_comb begin
        trial = {rem, quotient[W-1]};
        diff = trial - {1'b0, dsr};
        ge = trial >= {1'b0, dsr};
        done = cnt == CW'(1);
    end
    // Dividend shifts out of the quotient register as quotient bits shift in
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dsr <= '0;
            quotient <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            dsr <= divisor;
            quotient <= dividend;
            cnt <= CW'(W);
        end else if (cnt != '0) begin
            rem <= ge ? diff[W-1:0] : trial[W-1:0];
            quotient <= {quotient[W-2:0], ge};
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/freq_gen.sv
// freq_gen: BCD-programmed square-wave source; FREQ_GEN_PULSE_CNT_EN adds an f_out rising-edge counter
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input logic clk,
    input logic rst,
    freq_gen_if.slave bus
);
    localparam logic [ACC_W-1:0] HZ = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] F_MAX = ACC_W'(CLK_HZ / 2);
    localparam int KW = $clog2(CONV_CYC);
    state_t state, nxt;
    logic [DIGITS-1:0][BCD_W-1:0] dig;
    logic [ACC_W-1:0] bin, quo, half_new, pending, cnt;
    logic [KW-1:0] k;
    logic bad, err, run, f, go, bad_req, div_start, div_done, kill, tog;
    // Request acceptance, range check and toggle-engine decisions
    always_comb begin
        go = state == IDLE && bus.load;
        bad_req = bad || bin > F_MAX;
        div_start = state == CHECK && !bad_req && bin != '0;
        half_new = bin == '0 ? '0 : quo;
        kill = state == APPLY && half_new == '0;
        tog = run && cnt == '0 && !kill;
        bus.busy = state != IDLE;
        bus.err = err;
        bus.f_out = f;
    end
    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end
    // Next-state sequencing through conversion, check, divide and apply
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  nxt = bus.load ? CONV : IDLE;
            CONV:  nxt = k == '0 ? CHECK : CONV;
            CHECK: nxt = bad_req ? IDLE : bin == '0 ? APPLY : DIV;
            DIV:   nxt = div_done ? APPLY : DIV;
            APPLY: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    freq_gen_div #(.W(ACC_W)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .dividend(HZ),
        .divisor({bin[ACC_W-2:0], 1'b0}),
        .done(div_done),
        .quotient(quo)
    );
    // Digit capture, MSD-first BCD to binary accumulation and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dig <= '0;
            bin <= '0;
            k <= '0;
            bad <= 1'b0;
            err <= 1'b0;
        end else begin
            if (go) begin
                dig <= bus.d;
                bin <= '0;
                bad <= 1'b0;
                err <= 1'b0;
                k <= KW'(CONV_CYC - 1);
            end
            if (state == CONV) begin
                bin <= bin * ACC_W'(10) + ACC_W'(dig[k]);
                bad <= bad | (dig[k] > 4'd9);
                k <= k - 1'b1;
            end
            if (state == CHECK && bad_req) err <= 1'b1;
        end
    end
    // Toggle engine: new half-periods are picked up only at reloads, so f_out never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            cnt <= '0;
            run <= 1'b0;
            f <= 1'b0;
        end else begin
            if (state == APPLY) pending <= half_new;
            if (kill) begin
                run <= 1'b0;
                f <= 1'b0;
            end else if (run) begin
                f <= tog ? ~f : f;
                cnt <= tog ? pending - 1'b1 : cnt - 1'b1;
            end else if (pending != '0) begin
                run <= 1'b1;
                f <= 1'b0;
                cnt <= pending - 1'b1;
            end
        end
    end
`ifdef FREQ_GEN_PULSE_CNT_EN
    logic [ACC_W-1:0] pcnt;
    // Rising edges of f_out since the last accepted load
    always_ff @(posedge clk) begin
        if (rst || go) pcnt <= '0;
        else if (tog && !f) pcnt <= pcnt + 1'b1;
    end
    assign bus.pulse_cnt = pcnt;
`endif
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: randomized and directed checks of freq_gen at CLK_HZ=1000 against an arithmetic model
module tb_freq_gen;
    import freq_gen_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    freq_gen_if bus();
    freq_gen #(.CLK_HZ(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int total = 0, nbad = 0;
    int cyc = 0, last_edge = 0, ival = 0, edges = 0, rises = 0, minv = 1 << 30;
    int cur_half = 0, r_acc = 0;
    logic fprev = 1'b0;

    // Edge monitor sampled just after each rising clock edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.f_out !== fprev) begin
            ival = cyc - last_edge;
            last_edge = cyc;
            fprev = bus.f_out;
            edges++;
            if (bus.f_out === 1'b1) rises++;
            if (ival < minv) minv = ival;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [23:0] dv, output bit ok, output int half, output int bz);
        int f = 0;
        bit bb = 0;
        for (int i = 5; i >= 0; i--) begin
            int nib = int'(dv[i*4 +: 4]);
            if (nib > 9) bb = 1;
            f = f * 10 + nib;
        end
        ok = !bb && f <= 500;
        half = (ok && f > 0) ? 1000 / (2 * f) : 0;
        bz = !ok ? 7 : (f == 0 ? 8 : 40);
    endfunction

    function automatic logic [23:0] to_bcd(input int f);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(f % 10);
            f = f / 10;
        end
        return r;
    endfunction

    task automatic wait_edge(input int lim, output int n, output int iv);
        int e0 = edges;
        n = 0;
        while (edges == e0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        iv = (edges != e0) ? ival : -1;
    endtask

    task automatic prog(input logic [23:0] dv, input int w, input int poke, input string tag);
        bit ok;
        int h, bz, bc, k;
        logic e1;
        model(dv, ok, h, bz);
        @(negedge clk);
        bus.d = dv;
        bus.load = 1'b1;
        @(negedge clk);
        e1 = bus.err;
        r_acc = rises;
        bc = 0;
        k = 1;
        while (bus.busy && bc < 100) begin
            bc++;
            bus.load = (k < w) || (k == poke);
            if (k == poke) bus.d = 24'h000003;
            k++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk({tag, "_busy"}, bc, bz);
        chk({tag, "_errclr"}, e1, 0);
        chk({tag, "_err"}, bus.err, !ok);
        if (ok) cur_half = h;
    endtask

    task automatic check_ivals(input string tag, input int cnt_iv);
        int n, iv;
        for (int i = 0; i < cnt_iv; i++) begin
            wait_edge(600, n, iv);
            chk(tag, iv, cur_half);
        end
    endtask

    initial begin
        int n, iv, e0, r;
        bit ok;
        int h, bz;
        logic [23:0] dv;
        bus.load = 1'b0;
        bus.d = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_fout", bus.f_out, 0);
`ifdef FREQ_GEN_PULSE_CNT_EN
        chk("rst_pcnt", bus.pulse_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        prog(24'h000100, 1, 0, "t1");
        wait_edge(50, n, iv);
        chk("t1_first_rise", n, 6);
        chk("t1_rise_level", bus.f_out, 1);
        check_ivals("t1_half", 2);
        prog(24'h000500, 1, 0, "t2");
        wait_edge(600, n, iv);
        check_ivals("t2_half", 3);
        prog(24'h000501, 1, 0, "t2_over");
        check_ivals("t2_keep", 3);
        prog(24'hA00100, 1, 0, "t3_bcd");
        check_ivals("t3_keep", 2);
        prog(24'h000200, 1, 0, "t3_ok");
        wait_edge(600, n, iv);
        check_ivals("t3_half", 2);
        prog(24'h000003, 1, 0, "t4_slow");
        wait_edge(600, n, iv);
        check_ivals("t4_half166", 1);
        minv = 1 << 30;
        prog(24'h000100, 1, 0, "t4_fast");
        wait_edge(600, n, iv);
        chk("t4_finish_old", iv, 166);
        check_ivals("t4_half5", 2);
        chk("t4_min_pulse", minv, 5);
        prog(24'h000200, 3, 10, "t5_ign");
        wait_edge(600, n, iv);
        check_ivals("t5_ign_half", 3);
`ifdef FREQ_GEN_PULSE_CNT_EN
        chk("t5_pcnt", bus.pulse_cnt, rises - r_acc);
`endif
        prog(24'h000000, 1, 0, "t5_zero");
        chk("t5_zero_fout", bus.f_out, 0);
        e0 = edges;
        repeat (50) @(negedge clk);
        chk("t5_zero_still", edges - e0, 0);
        prog(24'h000250, 1, 0, "t6_pre");
        @(negedge clk);
        bus.d = 24'h000100;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", bus.busy, 0);
        chk("t6_err", bus.err, 0);
        chk("t6_fout", bus.f_out, 0);
`ifdef FREQ_GEN_PULSE_CNT_EN
        chk("t6_pcnt", bus.pulse_cnt, 0);
`endif
        rst = 1'b0;
        e0 = edges;
        repeat (30) @(negedge clk);
        chk("t6_stopped", edges - e0, 0);
        prog(24'h000250, 1, 0, "t6_post");
        wait_edge(600, n, iv);
        check_ivals("t6_half", 2);
        for (int t = 0; t < 12; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                dv = to_bcd($urandom_range(2, 500));
                dv[$urandom_range(0, 5)*4 +: 4] = 4'($urandom_range(10, 15));
            end else if (r == 2) begin
                dv = to_bcd($urandom_range(501, 999999));
            end else begin
                dv = to_bcd($urandom_range(2, 500));
            end
            model(dv, ok, h, bz);
            prog(dv, 1, 0, "rnd");
            if (ok) wait_edge(600, n, iv);
            check_ivals("rnd_half", 2);
        end
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
